// File: rtl/video_regs_pkg.sv
// video_regs_pkg: register map, CTRL bit positions and reset constants for wb_video_regs
package video_regs_pkg;
  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_VERSION = 4'h1;
  localparam logic [3:0] REG_FG_R    = 4'h2;
  localparam logic [3:0] REG_FG_G    = 4'h3;
  localparam logic [3:0] REG_FG_B    = 4'h4;
  localparam logic [3:0] REG_STATUS  = 4'h5;
  localparam logic [3:0] REG_IRQ_EN  = 4'h6;
  localparam logic [3:0] REG_FCNT_LO = 4'h7;
  localparam logic [3:0] REG_FCNT_HI = 4'h8;
  localparam logic [3:0] REG_COMMIT  = 4'h9;
  localparam int CTRL_EN   = 6;
  localparam int CTRL_PEND = 7;
  localparam logic [23:0] RST_COLOR = 24'hFFFFFF;
endpackage

// File: rtl/wb_video_regs.sv
// wb_video_regs: Wishbone register bank with frame-synchronous commit, frame counter and vblank IRQ
module wb_video_regs
  import video_regs_pkg::*;
#(
  parameter int MODE_W = 2,
  parameter int CNT_W = 16,
  parameter bit SHADOW = 1'b1,
  parameter logic [7:0] VERSION = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wb_adr_i,
  input  logic [7:0]        wb_dat_i,
  output logic [7:0]        wb_dat_o,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  output logic              wb_ack_o,
  input  logic              frame_start_i,
  input  logic              vblank_i,
  output logic [MODE_W-1:0] pattern_mode_o,
  output logic              enable_o,
  output logic [23:0]       fg_color_o,
  output logic              irq_o
);
  logic [3:0] adr;
  logic req, wr, unused_adr;
  logic [MODE_W-1:0] stg_mode;
  logic stg_en, pending, irq_flag, irq_en;
  logic [23:0] stg_fg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-9:0] cnt_hold;
  logic [7:0] ctrl_rd, rdata;
  assign adr = wb_adr_i[3:0];
  assign unused_adr = ^wb_adr_i[7:4];
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  // writes land at the end of the ack cycle, so a coincident frame_start sees pre-write state
  assign wr = wb_cyc_i & wb_stb_i & wb_ack_o & wb_we_i;
  assign irq_o = irq_flag & irq_en;
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[MODE_W-1:0] = stg_mode;
    ctrl_rd[CTRL_EN] = stg_en;
    ctrl_rd[CTRL_PEND] = pending;
  end
  assign rdata = adr == REG_CTRL    ? ctrl_rd :
                 adr == REG_VERSION ? VERSION :
                 adr == REG_FG_R    ? stg_fg[23:16] :
                 adr == REG_FG_G    ? stg_fg[15:8] :
                 adr == REG_FG_B    ? stg_fg[7:0] :
                 adr == REG_STATUS  ? {6'b0, vblank_i, irq_flag} :
                 adr == REG_IRQ_EN  ? {7'b0, irq_en} :
                 adr == REG_FCNT_LO ? cnt[7:0] :
                 adr == REG_FCNT_HI ? 8'(cnt_hold) : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      stg_mode <= '0;
      stg_en <= 1'b1;
      stg_fg <= RST_COLOR;
      pending <= 1'b0;
      irq_flag <= 1'b0;
      irq_en <= 1'b0;
      cnt <= '0;
      cnt_hold <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req && !wb_we_i ? rdata : '0;
      if (req && !wb_we_i && adr == REG_FCNT_LO) cnt_hold <= cnt[CNT_W-1:8];
      if (wr && adr == REG_CTRL) begin
        stg_mode <= wb_dat_i[MODE_W-1:0];
        stg_en <= wb_dat_i[CTRL_EN];
      end
      if (wr && adr == REG_FG_R) stg_fg[23:16] <= wb_dat_i;
      if (wr && adr == REG_FG_G) stg_fg[15:8] <= wb_dat_i;
      if (wr && adr == REG_FG_B) stg_fg[7:0] <= wb_dat_i;
      if (wr && adr == REG_IRQ_EN) irq_en <= wb_dat_i[0];
      pending <= SHADOW && ((wr && adr == REG_COMMIT) || (pending && !frame_start_i));
      irq_flag <= frame_start_i || (irq_flag && !(wr && adr == REG_STATUS && wb_dat_i[0]));
      cnt <= cnt + CNT_W'(frame_start_i);
    end
  generate
    if (SHADOW) begin : g_shadow
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          pattern_mode_o <= '0;
          enable_o <= 1'b1;
          fg_color_o <= RST_COLOR;
        end else if (frame_start_i && pending) begin
          pattern_mode_o <= stg_mode;
          enable_o <= stg_en;
          fg_color_o <= stg_fg;
        end
    end else begin : g_direct
      assign pattern_mode_o = stg_mode;
      assign enable_o = stg_en;
      assign fg_color_o = stg_fg;
    end
  endgenerate
endmodule
